// File: rtl/search_sequencer.sv
// -----------------------------------------------------------------------------
// search_sequencer
//
// Drives the shared byte-search datapath on behalf of two requesters. Each job
// is arbitrated round-robin, the datapath is cleared and started, and the
// granted requester's bytes are streamed into it over a valid/ready handshake.
// The job ends on dp_found or once the requested length has been streamed and a
// short drain window has passed. It then reports hit, hit_pos and done.
//
// Build option:
//   SEARCH_TIMEOUT_EN  when defined, a FEED-state stall timer aborts a job whose
//                      requester withholds s_valid for TMO_CYC consecutive
//                      cycles (err=1). When undefined, FEED waits indefinitely
//                      and err is tied to 0.
//
// Parameters:
//   LEN_W      width of job length and hit position (max job 2^LEN_W-1 bytes)
//   DRAIN_CYC  cycles dp_found is still watched after the last byte
//   TMO_CYC    stall limit in cycles (SEARCH_TIMEOUT_EN builds only)
//
// Ports:
//   clk        clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   req        per-requester level request, held until done
//   req_len    job lengths, requester 0 in the low LEN_W bits
//   s_data     byte streams, requester 0 in [7:0], requester 1 in [15:8]
//   s_valid    per-requester byte valid
//   s_ready    per-requester byte accept (only the granted bit can be high)
//   gnt        one-hot grant, held for the whole job
//   done       one-cycle completion pulse to the granted requester
//   hit        pattern found (valid from the done cycle)
//   hit_pos    0-based index of the matching byte (valid when hit=1)
//   err        job aborted by stall timeout (valid from the done cycle)
//   busy       high in every state except IDLE
//   dp_reset   active-high datapath reset
//   dp_start   datapath start pulse
//   dp_a       byte presented to the datapath (registered)
//   dp_found   datapath match indication
// -----------------------------------------------------------------------------
module search_sequencer #(
  parameter int LEN_W     = 5,
  parameter int DRAIN_CYC = 2,
  parameter int TMO_CYC   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [2*LEN_W-1:0] req_len,
  input  logic [15:0]        s_data,
  input  logic [1:0]         s_valid,
  output logic [1:0]         s_ready,
  output logic [1:0]         gnt,
  output logic [1:0]         done,
  output logic               hit,
  output logic [LEN_W-1:0]   hit_pos,
  output logic               err,
  output logic               busy,
  output logic               dp_reset,
  output logic               dp_start,
  output logic [7:0]         dp_a,
  input  logic               dp_found
);

  // One timer serves both the drain window (DRAIN) and the stall limit (FEED);
  // the two are never live at the same time, so it is sized for the larger.
  localparam int TMR_MAX = (DRAIN_CYC > TMO_CYC) ? DRAIN_CYC : TMO_CYC;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ARM,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic             g;          // index of the granted requester
  logic             last;       // requester granted most recently
  logic [LEN_W-1:0] len;        // latched job length
  logic [LEN_W-1:0] cnt;        // bytes accepted in this job
  logic [TMR_W-1:0] timer;

  // ---------------------------------------------------------------------------
  // Arbitration and stream selection
  // ---------------------------------------------------------------------------
  logic             any_req;
  logic             winner;
  logic             sel_valid;
  logic [7:0]       sel_data;
  logic             accept;
  logic [LEN_W-1:0] cnt_inc;
  logic             feed_last;
  logic             drain_expire;
  logic             stall_expire;

  assign any_req   = |req;
  // On a tie the requester that was not served last wins.
  assign winner    = (req == 2'b11) ? ~last : req[1];
  assign sel_valid = s_valid[g];
  assign sel_data  = g ? s_data[15:8] : s_data[7:0];

  // s_ready is ~dp_found in FEED, so a byte is never taken in the found cycle.
  assign accept    = (state == S_FEED) && sel_valid && !dp_found;
  assign cnt_inc   = cnt + 1'b1;
  // FEED leaves on the edge that accepts byte number len, so cnt never wraps.
  assign feed_last = accept && (cnt_inc == len);

  assign drain_expire = (timer <= TMR_W'(1));

`ifdef SEARCH_TIMEOUT_EN
  logic err_q;

  // The timer is reloaded with TMO_CYC on every cycle with valid data and
  // counts down on idle cycles; reaching 1 on an idle cycle is the
  // TMO_CYC-th consecutive stall.
  assign stall_expire = (state == S_FEED) && !dp_found && !sel_valid &&
                        (timer == TMR_W'(1));
  assign err          = err_q;
`else
  assign stall_expire = 1'b0;
  assign err          = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_nxt unassigned (which would infer a latch).
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_CLR;
      S_CLR:   state_nxt = (len == '0) ? S_DONE : S_ARM;
      S_ARM:   state_nxt = S_FEED;
      S_FEED: begin
        if (dp_found || stall_expire) state_nxt = S_DONE;
        else if (feed_last)           state_nxt = S_DRAIN;
      end
      S_DRAIN: if (dp_found || drain_expire) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ready  = 2'b00;
    done     = 2'b00;
    dp_start = 1'b0;
    // The datapath is held in reset for as long as this block is.
    dp_reset = ~reset;
    busy     = (state != S_IDLE);
    case (state)
      S_CLR:   dp_reset   = 1'b1;
      S_ARM:   dp_start   = 1'b1;
      S_FEED:  s_ready[g] = ~dp_found;
      S_DONE:  done[g]    = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job registers: grant, length, byte count, datapath byte, results, timer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g       <= 1'b0;
      last    <= 1'b1;          // requester 0 wins the first tie
      gnt     <= 2'b00;
      len     <= '0;
      cnt     <= '0;
      dp_a    <= 8'h00;
      hit     <= 1'b0;
      hit_pos <= '0;
      timer   <= '0;
`ifdef SEARCH_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            g       <= winner;
            last    <= winner;
            gnt     <= winner ? 2'b10 : 2'b01;
            len     <= winner ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
            cnt     <= '0;
            hit     <= 1'b0;
            hit_pos <= '0;
`ifdef SEARCH_TIMEOUT_EN
            err_q   <= 1'b0;
            timer   <= TMR_W'(TMO_CYC);
`endif
          end
        end

        S_FEED: begin
          if (accept) begin
            dp_a <= sel_data;
            cnt  <= cnt_inc;
          end
          if (dp_found) begin
            // dp_found follows the byte it matched, so the match is the
            // previously accepted byte; clamp at 0 if none was accepted.
            hit     <= 1'b1;
            hit_pos <= (cnt == '0) ? '0 : cnt - 1'b1;
          end else if (feed_last) begin
            timer <= TMR_W'(DRAIN_CYC);
          end
`ifdef SEARCH_TIMEOUT_EN
          else if (stall_expire) begin
            err_q <= 1'b1;
            hit   <= 1'b0;
          end else if (sel_valid) begin
            timer <= TMR_W'(TMO_CYC);
          end else begin
            timer <= timer - 1'b1;
          end
`endif
        end

        S_DRAIN: begin
          if (dp_found) begin
            // A late match can only belong to the final byte.
            hit     <= 1'b1;
            hit_pos <= len - 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_DONE: gnt <= 2'b00;

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_search_sequencer.sv
// -----------------------------------------------------------------------------
// tb_search_sequencer
//
// Table-driven bench for search_sequencer. Each table row describes one job
// (requests, lengths, when the datapath model raises dp_found, optional stall
// gap) together with the result expected for it. The expected record goes into
// a scoreboard queue when the job is launched and is popped and compared when
// the DUT pulses done. Hand-written sequences cover reset values and a reset
// that lands in the middle of a job.
// -----------------------------------------------------------------------------
module tb_search_sequencer;

  localparam int LEN_W = 5;

  localparam int M_NONE  = 0;  // dp_found never raised
  localparam int M_FEED  = 1;  // raised once arg bytes have been accepted
  localparam int M_DRAIN = 2;  // raised in drain cycle arg

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         req;
  logic [2*LEN_W-1:0] req_len;
  logic [15:0]        s_data;
  logic [1:0]         s_valid;
  logic [1:0]         s_ready;
  logic [1:0]         gnt;
  logic [1:0]         done;
  logic               hit;
  logic [LEN_W-1:0]   hit_pos;
  logic               err;
  logic               busy;
  logic               dp_reset;
  logic               dp_start;
  logic [7:0]         dp_a;
  logic               dp_found;

  search_sequencer #(
    .LEN_W    (LEN_W),
    .DRAIN_CYC(2),
    .TMO_CYC  (15)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_len (req_len),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .gnt     (gnt),
    .done    (done),
    .hit     (hit),
    .hit_pos (hit_pos),
    .err     (err),
    .busy    (busy),
    .dp_reset(dp_reset),
    .dp_start(dp_start),
    .dp_a    (dp_a),
    .dp_found(dp_found)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    int         l0;
    int         l1;
    int         mode;
    int         arg;
    int         gap_after;
    int         gap_len;
    bit         keep;       // keep req asserted into the next job
    logic [1:0] exp_gnt;
    bit         exp_hit;
    int         exp_pos;
    bit         exp_err;
    int         exp_bytes;
    int         exp_starts;
  } vec_t;

  typedef struct {
    logic [1:0] gnt;
    bit         hit;
    int         pos;
    bit         err;
    int         bytes;
    int         starts;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[12];
  vec_t post_rst;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one job from launch to done and compares it against the scoreboard.
  task automatic run_job(input vec_t v, input int idx);
    exp_t       e;
    int         lg;
    int         acc;
    int         drain_idx;
    int         gap_left;
    bit         gap_done;
    bit         saw_start;
    int         starts;
    int         resets;
    int         viol;
    bit         got_done;
    logic [7:0] last_byte;

    e.gnt    = v.exp_gnt;
    e.hit    = v.exp_hit;
    e.pos    = v.exp_pos;
    e.err    = v.exp_err;
    e.bytes  = v.exp_bytes;
    e.starts = v.exp_starts;
    sb_q.push_back(e);

    lg        = v.exp_gnt[1] ? v.l1 : v.l0;
    acc       = 0;
    drain_idx = 0;
    gap_left  = 0;
    gap_done  = 1'b0;
    saw_start = 1'b0;
    starts    = 0;
    resets    = 0;
    viol      = 0;
    got_done  = 1'b0;
    last_byte = 8'h00;

    req      = v.req;
    req_len  = {v.l1[LEN_W-1:0], v.l0[LEN_W-1:0]};
    dp_found = 1'b0;
    s_valid  = v.req;

    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      @(negedge clk);
      // Datapath and requester models for this cycle.
      if (saw_start && lg > 0 && acc == lg) drain_idx++;
      dp_found = (v.mode == M_FEED  && saw_start && acc >= v.arg) ||
                 (v.mode == M_DRAIN && v.arg > 0 && drain_idx >= v.arg);
      if (v.gap_len > 0 && !gap_done && acc == v.gap_after) begin
        gap_left = v.gap_len;
        gap_done = 1'b1;
      end
      s_valid = (gap_left > 0) ? 2'b00 : v.req;
      s_data  = {8'h50 + 8'(acc), 8'hA0 + 8'(acc)};
      #1;
      if (gnt != v.exp_gnt || (s_ready & ~gnt) != 2'b00) viol++;
      if (dp_start) begin
        starts++;
        saw_start = 1'b1;
      end
      if (dp_reset) resets++;
      if (gap_left > 0) begin
        gap_left--;
`ifndef SEARCH_TIMEOUT_EN
        if (gap_left == 0) begin
          check($sformatf("j%0d_stall_busy", idx), 32'(busy), 32'd1);
          check($sformatf("j%0d_stall_err", idx), 32'(err), 32'd0);
          check($sformatf("j%0d_stall_ready", idx), 32'(s_ready), 32'(v.exp_gnt));
        end
`endif
      end
      if ((s_valid & s_ready) != 2'b00) begin
        last_byte = v.exp_gnt[1] ? s_data[15:8] : s_data[7:0];
        acc++;
      end
      if (done != 2'b00) got_done = 1'b1;
    end

    if (sb_q.size() > 0) e = sb_q.pop_front();
    check($sformatf("j%0d_done_seen", idx), 32'(got_done), 32'd1);
    if (got_done) begin
      check($sformatf("j%0d_done", idx), 32'(done), 32'(e.gnt));
      check($sformatf("j%0d_gnt", idx), 32'(gnt), 32'(e.gnt));
      check($sformatf("j%0d_hit", idx), 32'(hit), 32'(e.hit));
      if (e.hit) check($sformatf("j%0d_hit_pos", idx), 32'(hit_pos), e.pos);
      check($sformatf("j%0d_err", idx), 32'(err), 32'(e.err));
      check($sformatf("j%0d_bytes", idx), acc, e.bytes);
      check($sformatf("j%0d_starts", idx), starts, e.starts);
      check($sformatf("j%0d_dp_reset_cycles", idx), resets, 32'd1);
      check($sformatf("j%0d_protocol", idx), viol, 32'd0);
      if (e.bytes > 0) check($sformatf("j%0d_dp_a", idx), 32'(dp_a), 32'(last_byte));
    end

    // The cycle after done is IDLE; done must have been a single pulse.
    @(negedge clk);
    dp_found = 1'b0;
    s_valid  = 2'b00;
    if (!v.keep) req = 2'b00;
    #1;
    check($sformatf("j%0d_idle_busy", idx), 32'(busy), 32'd0);
    check($sformatf("j%0d_idle_gnt", idx), 32'(gnt), 32'd0);
    check($sformatf("j%0d_idle_done", idx), 32'(done), 32'd0);
  endtask

  initial begin
    int seen;

    // req, l0, l1, mode, arg, gap_after, gap_len, keep,
    // exp_gnt, exp_hit, exp_pos, exp_err, exp_bytes, exp_starts
    tbl[0]  = '{2'b11, 3, 3,  M_NONE,  0, 0, 0,  1'b1, 2'b01, 1'b0, 0, 1'b0, 3,  1};
    tbl[1]  = '{2'b11, 3, 3,  M_FEED,  1, 0, 0,  1'b1, 2'b10, 1'b1, 0, 1'b0, 1,  1};
    tbl[2]  = '{2'b11, 2, 4,  M_NONE,  0, 0, 0,  1'b0, 2'b01, 1'b0, 0, 1'b0, 2,  1};
    tbl[3]  = '{2'b01, 4, 0,  M_FEED,  3, 0, 0,  1'b0, 2'b01, 1'b1, 2, 1'b0, 3,  1};
    tbl[4]  = '{2'b10, 0, 0,  M_NONE,  0, 0, 0,  1'b0, 2'b10, 1'b0, 0, 1'b0, 0,  0};
    tbl[5]  = '{2'b01, 5, 0,  M_NONE,  0, 0, 0,  1'b0, 2'b01, 1'b0, 0, 1'b0, 5,  1};
    tbl[6]  = '{2'b01, 5, 0,  M_DRAIN, 2, 0, 0,  1'b0, 2'b01, 1'b1, 4, 1'b0, 5,  1};
    tbl[7]  = '{2'b10, 0, 5,  M_DRAIN, 1, 0, 0,  1'b0, 2'b10, 1'b1, 4, 1'b0, 5,  1};
    tbl[8]  = '{2'b01, 4, 0,  M_FEED,  0, 0, 0,  1'b0, 2'b01, 1'b1, 0, 1'b0, 0,  1};
    tbl[9]  = '{2'b10, 0, 31, M_NONE,  0, 0, 0,  1'b0, 2'b10, 1'b0, 0, 1'b0, 31, 1};
`ifdef SEARCH_TIMEOUT_EN
    tbl[10] = '{2'b01, 8, 0,  M_NONE,  0, 2, 20, 1'b0, 2'b01, 1'b0, 0, 1'b1, 2,  1};
`else
    tbl[10] = '{2'b01, 8, 0,  M_NONE,  0, 2, 20, 1'b0, 2'b01, 1'b0, 0, 1'b0, 8,  1};
`endif
    tbl[11] = '{2'b11, 3, 2,  M_NONE,  0, 0, 0,  1'b0, 2'b10, 1'b0, 0, 1'b0, 2,  1};
    post_rst = '{2'b10, 0, 2, M_NONE, 0, 0, 0,  1'b0, 2'b10, 1'b0, 0, 1'b0, 2,  1};

    reset    = 1'b0;
    req      = 2'b00;
    req_len  = '0;
    s_data   = 16'h0000;
    s_valid  = 2'b00;
    dp_found = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_dp_reset", 32'(dp_reset), 32'd1);
    check("rst_dp_start", 32'(dp_start), 32'd0);
    check("rst_dp_a", 32'(dp_a), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_job(tbl[i], i);

    // Reset landing in FEED: the job is abandoned with no done pulse.
    @(negedge clk);
    req     = 2'b01;
    req_len = {5'd0, 5'd6};
    s_valid = 2'b01;
    s_data  = 16'h3C3C;
    seen    = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge clk);
      #1;
      if (s_ready[0]) seen++;
    end
    check("midrst_reached_feed", seen, 32'd2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_dp_reset", 32'(dp_reset), 32'd1);
    check("midrst_dp_a", 32'(dp_a), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("midrst_no_done_%0d", c), 32'(done), 32'd0);
    end
    @(negedge clk);
    reset   = 1'b1;
    req     = 2'b00;
    s_valid = 2'b00;
    run_job(post_rst, 12);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/search_sequencer.md
Name: search_sequencer

Overview:
- Sequences the shared byte-search datapath (8-bit A input, start, active-high reset, found output) on behalf of two requesters.
- Per job:
  - round-robin arbitrates between requesters;
  - clears the datapath, pulses start, then streams the granted requester's bytes into A with a valid/ready handshake;
  - stops on found or when the job length is exhausted, then reports hit, hit position and done.
- Sits between the requesting control logic and the datapath instance; it is the only driver of the datapath's inputs.

Parameters:
- LEN_W, 5, width of the job length and hit position (max job = 2^LEN_W-1 bytes)
- DRAIN_CYC, 2, cycles to keep watching dp_found after the last byte (covers datapath latency)
- TMO_CYC, 15, stall limit in cycles; used only with SEARCH_TIMEOUT_EN

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  2  per-requester job request, level, held until done
- req_len  in  2*LEN_W  job length; [LEN_W-1:0] for requester 0, upper bits for requester 1
- s_data  in  16  byte stream; [7:0] requester 0, [15:8] requester 1
- s_valid  in  2  per-requester byte valid
- s_ready  out  2  per-requester byte accept
- gnt  out  2  one-hot grant, held for the whole job
- done  out  2  one-cycle job-complete pulse to the granted requester
- hit  out  1  job result: pattern found; valid from the done cycle
- hit_pos  out  LEN_W  0-based index of the matching byte; valid when hit=1
- err  out  1  job aborted by timeout; valid from the done cycle
- busy  out  1  high in every state except IDLE
- dp_reset  out  1  active-high reset to the datapath
- dp_start  out  1  start to the datapath
- dp_a  out  8  byte to the datapath
- dp_found  in  1  found from the datapath

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; outputs gnt, done, s_ready, dp_start, hit, hit_pos, err and busy all 0; dp_a=0.
  - Round-robin pointer last=1, so requester 0 wins first.
  - dp_reset=1 while reset is low.
  - Reset mid-job abandons the job with no done pulse.
- States and transitions:
  - IDLE: if any req, grant the winner, latch its req_len into len, set last=winner, clear hit/hit_pos/err, go CLR.
    - Tie rule: on simultaneous requests, grant the requester other than last.
  - CLR (1 cycle): dp_reset=1.
    - len==0: go DONE; the datapath is not started and hit stays 0.
    - Otherwise: go ARM.
  - ARM (1 cycle): dp_start=1, then go FEED.
  - FEED: s_ready[g] = ~dp_found (combinational). A byte is accepted when s_valid[g] & s_ready[g].
    - dp_a is registered: it loads the accepted byte at the acceptance edge and holds otherwise.
    - cnt counts accepted bytes.
    - dp_found=1: hit=1, hit_pos=cnt-1, saturating at 0; go DONE.
    - Else, if cnt reaches len: go DRAIN.
  - DRAIN: s_ready=0; a down-counter is loaded with DRAIN_CYC.
    - dp_found=1 in any DRAIN cycle: hit=1, hit_pos=len-1; go DONE.
    - Counter expiry without found: go DONE with hit=0.
  - DONE (1 cycle): done[g]=1; gnt cleared at the next edge; go IDLE.
    - hit, hit_pos and err hold until the next grant.
- gnt is one-hot or zero, never both bits. Non-granted s_ready is always 0.
- Bytes offered after found or after len is reached are not accepted; the requester discards them on done.
- req dropping mid-job is ignored; the job runs to DONE.
- cnt width is LEN_W; it cannot wrap because FEED exits at cnt==len.
- Back-to-back jobs: the earliest next grant is in the cycle after DONE.

Optional Feature:
- Macro: SEARCH_TIMEOUT_EN.
- Defined: in FEED a stall counter counts consecutive cycles with s_valid[g]=0 and resets on each accepted byte.
  - Reaching TMO_CYC sets err=1, hit=0 and goes DONE.
- Undefined: no stall counter; FEED waits indefinitely; err is tied to 0.

Test Plan:
- Only req=01, len=4, bytes streamed with no gaps, dp_found rises while cnt=3 -> hit=1, hit_pos=2; done=01 pulse; exactly 3 bytes accepted.
- req=11 from IDLE after reset -> gnt=01 first job, then gnt=10; with both still requesting, grants alternate 01,10,01.
- len=0 -> CLR then DONE; no dp_start pulse; done pulse; hit=0.
- len=5, no found -> 5 bytes accepted, DRAIN of 2 cycles, done with hit=0. Variant: found in the 2nd DRAIN cycle -> hit=1, hit_pos=4.
- reset driven low during FEED -> all outputs 0 immediately, dp_reset=1, no done. After release, a fresh req=10 is granted gnt=10.
- SEARCH_TIMEOUT_EN, TMO_CYC=15, s_valid held low 15 cycles after the 2nd byte -> err=1, hit=0, done pulse. Without the macro: still in FEED, err=0.
